// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end with a registered PC, a single-outstanding
// request/ack port to instruction memory and a prefetch queue toward decode.
// Branch redirects flush the queue and restart fetch at a new address.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/flush performance counters;
// when undefined both counter outputs are tied to zero.
module fetch_unit #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_STEP  = 1,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc,
  input  logic               dec_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [31:0]        fetch_count,
  output logic [15:0]        flush_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PC_W-1:0]  RST_PC  = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0]  STEP_C  = PC_W'(PC_STEP);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e             state_q;
  logic               req_q;
  logic [PC_W-1:0]    addr_q;
  logic [PC_W-1:0]    tgt_q;

  logic [PC_W-1:0]    pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;

  logic q_wr;
  logic q_pop;

  // Queue write on a completed, non-redirected fetch; pop on decode handshake
  always_comb begin
    q_wr    = (state_q == ST_REQ) && imem_ack && !redirect;
    q_pop   = (count_q != '0) && dec_ready;
    count_d = count_q + CNT_W'(q_wr) - CNT_W'(q_pop);
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign dec_valid = (count_q != '0);
  assign dec_instr = instr_mem_q[rd_ptr_q];
  assign dec_pc    = pc_mem_q[rd_ptr_q];

  // Fetch FSM: owns the request strobe, the fetch address and the pending redirect target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= RST_PC;
      tgt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (redirect) begin
            addr_q  <= redirect_pc;
            state_q <= ST_REQ;
            req_q   <= 1'b1;
          end else if (count_q < DEPTH_C) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (redirect) begin
            if (imem_ack) begin
              // transaction finished this cycle: restart directly at the target
              addr_q <= redirect_pc;
            end else begin
              // request still in flight: hold it and swallow its data later
              tgt_q   <= redirect_pc;
              state_q <= ST_DISCARD;
            end
          end else if (imem_ack) begin
            addr_q <= addr_q + STEP_C;
            if (count_d >= DEPTH_C) begin
              state_q <= ST_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        ST_DISCARD: begin
          if (redirect) begin
            if (imem_ack) begin
              addr_q  <= redirect_pc;
              state_q <= ST_REQ;
            end else begin
              tgt_q <= redirect_pc;
            end
          end else if (imem_ack) begin
            addr_q  <= tgt_q;
            state_q <= ST_REQ;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Prefetch queue storage and pointers; a redirect empties it after any same-cycle pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (q_wr) begin
        pc_mem_q[wr_ptr_q]    <= addr_q;
        instr_mem_q[wr_ptr_q] <= imem_rdata;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      if (q_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [15:0] flush_cnt_q;

  // Performance counters: queue writes and accepted redirects, both free-running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (q_wr) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (redirect) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign fetch_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a latency-programmable memory model
// and a second instance reset to 8'hFE for PC wrap-around.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dec_valid;
  logic [15:0] dec_instr;
  logic [7:0]  dec_pc;
  logic        dec_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [31:0] fetch_count;
  logic [15:0] flush_count;

  logic        w_req;
  logic [7:0]  w_addr;
  logic        w_valid;
  logic [15:0] w_instr;
  logic [7:0]  w_pc;
  logic        w_redirect;
  logic [7:0]  w_redirect_pc;
  logic [31:0] w_fetch_count;
  logic [15:0] w_flush_count;

  int   lat;
  int   wcnt;
  logic ack_pulse;
  int   n_checks;
  int   n_fail;

  fetch_unit u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_count (fetch_count),
    .flush_count (flush_count)
  );

  fetch_unit #(.RESET_PC(8'hFE)) u_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_ack    (w_req),
    .imem_rdata  (16'h1000 + {8'h00, w_addr}),
    .dec_valid   (w_valid),
    .dec_instr   (w_instr),
    .dec_pc      (w_pc),
    .dec_ready   (1'b1),
    .redirect    (w_redirect),
    .redirect_pc (w_redirect_pc),
    .fetch_count (w_fetch_count),
    .flush_count (w_flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: zero-wait (ack follows req) or ack after lat cycles of request
  assign imem_ack   = (lat == 0) ? imem_req : ack_pulse;
  assign imem_rdata = 16'h1000 + {8'h00, imem_addr};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt      <= 0;
      ack_pulse <= 1'b0;
    end else if (ack_pulse) begin
      ack_pulse <= 1'b0;
      wcnt      <= 0;
    end else if (imem_req && lat > 0) begin
      if (wcnt + 1 >= lat - 1) ack_pulse <= 1'b1;
      wcnt <= wcnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int latency, input logic ready);
    @(negedge clk);
    rst_n       = 1'b0;
    lat         = latency;
    dec_ready   = ready;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] exp_fc;
    logic [63:0] exp_flc;
    int          acks;
    logic        found;

    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    lat           = 0;
    dec_ready     = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = 8'h00;
    w_redirect    = 1'b0;
    w_redirect_pc = 8'h00;

`ifdef FETCH_PERF_CNT_EN
    exp_fc  = 64'd10;
    exp_flc = 64'd2;
`else
    exp_fc  = 64'd0;
    exp_flc = 64'd0;
`endif

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_req",   64'(imem_req),    64'd0);
    check_eq("rst_addr",  64'(imem_addr),   64'd0);
    check_eq("rst_valid", 64'(dec_valid),   64'd0);
    check_eq("rst_instr", 64'(dec_instr),   64'd0);
    check_eq("rst_pc",    64'(dec_pc),      64'd0);
    check_eq("rst_fcnt",  64'(fetch_count), 64'd0);
    check_eq("rst_flcnt", 64'(flush_count), 64'd0);
    check_eq("rst_waddr", 64'(w_addr),      64'hFE);

    // Streaming with zero-wait memory; wrap instance runs alongside
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("s_req1",  64'(imem_req),  64'd1);
    check_eq("s_addr1", 64'(imem_addr), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("s_valid", 64'(dec_valid), 64'd1);
      check_eq("s_pc",    64'(dec_pc),    64'(i));
      check_eq("s_instr", 64'(dec_instr), 64'h1000 + 64'(i));
      if (i < 4) begin
        check_eq("wrap_valid", 64'(w_valid), 64'd1);
        check_eq("wrap_pc",    64'(w_pc),    (64'hFE + 64'(i)) & 64'hFF);
      end
    end

    // Back-pressure: queue fills with DEPTH entries, then drains in order
    do_reset(0, 1'b0);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req && imem_ack) acks++;
    end
    check_eq("bp_acks",  64'(acks),      64'd4);
    check_eq("bp_req",   64'(imem_req),  64'd0);
    check_eq("bp_valid", 64'(dec_valid), 64'd1);
    check_eq("bp_head",  64'(dec_pc),    64'd0);
    check_eq("bp_instr", 64'(dec_instr), 64'h1000);
    dec_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      check_eq("drain_valid", 64'(dec_valid), 64'd1);
      check_eq("drain_pc",    64'(dec_pc),    64'(i));
      if (i == 2) begin
        check_eq("resume_req",  64'(imem_req),  64'd1);
        check_eq("resume_addr", 64'(imem_addr), 64'd4);
      end
    end

    // Redirect while a slow request is in flight
    do_reset(3, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 8'h05) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("inflight_seen_pc5", 64'(found), 64'd1);
    @(negedge clk);
    check_eq("inflight_noack", 64'(imem_ack), 64'd0);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    @(negedge clk);
    redirect = 1'b0;
    check_eq("disc_req",   64'(imem_req),  64'd1);
    check_eq("disc_addr",  64'(imem_addr), 64'd5);
    check_eq("disc_valid", 64'(dec_valid), 64'd0);
    @(negedge clk);
    check_eq("tgt_req",   64'(imem_req),  64'd1);
    check_eq("tgt_addr",  64'(imem_addr), 64'h40);
    check_eq("tgt_valid", 64'(dec_valid), 64'd0);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dec_valid) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("tgt_seen",  64'(found),     64'd1);
    check_eq("tgt_pc",    64'(dec_pc),    64'h40);
    check_eq("tgt_instr", 64'(dec_instr), 64'h1040);

    // Redirect coincident with ack, twice, then counter check
    do_reset(0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_eq("co_pc0", 64'(dec_pc), 64'd0);
    @(negedge clk);
    check_eq("co_ack",  64'(imem_ack),  64'd1);
    check_eq("co_addr", 64'(imem_addr), 64'd2);
    redirect    = 1'b1;
    redirect_pc = 8'h80;
    @(negedge clk);
    redirect = 1'b0;
    check_eq("co_req",   64'(imem_req),  64'd1);
    check_eq("co_raddr", 64'(imem_addr), 64'h80);
    check_eq("co_flush", 64'(dec_valid), 64'd0);
    @(negedge clk);
    check_eq("co_valid", 64'(dec_valid), 64'd1);
    check_eq("co_pc",    64'(dec_pc),    64'h80);
    check_eq("co_instr", 64'(dec_instr), 64'h1080);
    @(negedge clk);
    check_eq("co_pc81", 64'(dec_pc), 64'h81);
    @(negedge clk);
    @(negedge clk);
    check_eq("co2_addr", 64'(imem_addr), 64'h84);
    redirect    = 1'b1;
    redirect_pc = 8'h90;
    @(negedge clk);
    redirect = 1'b0;
    check_eq("co2_raddr", 64'(imem_addr), 64'h90);
    for (int i = 0; i < 4; i++) @(negedge clk);
    check_eq("co2_pc",   64'(dec_pc),      64'h93);
    check_eq("cnt_fetch", 64'(fetch_count), exp_fc);
    check_eq("cnt_flush", 64'(flush_count), exp_flc);

    // Asynchronous reset mid-stream clears request and head immediately
    rst_n = 1'b0;
    #1;
    check_eq("arst_req",   64'(imem_req),  64'd0);
    check_eq("arst_addr",  64'(imem_addr), 64'd0);
    check_eq("arst_valid", 64'(dec_valid), 64'd0);
    check_eq("arst_instr", 64'(dec_instr), 64'd0);
    check_eq("arst_fcnt",  64'(fetch_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
